// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory response return path.
// Provides index-width helper and the response payload struct.
package mem_pkg;

  localparam int MEM_DATA_W = 32;

  // Width of an index into n ports; at least one bit so that
  // single-port builds still have a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/std_mem_intf.sv
// Response channel: valid/data from producer, ready from consumer.
// Modports: in (consumer side), out (producer side).
interface std_mem_intf #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/mem_index_fifo.sv
// Small FIFO of port indices with wrap-bit pointers.
// Ports: clk, rst, push/din, pop, head, empty, full.
module mem_index_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_idx, wr_idx;
  logic             rd_wrap, wr_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx  <= '0;
      wr_idx  <= '0;
      rd_wrap <= 1'b0;
      wr_wrap <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        if (wr_idx == LAST) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx <= wr_idx + AW'(1);
        end
      end
      if (pop) begin
        if (rd_idx == LAST) begin
          rd_idx  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end

  assign head  = mem[rd_idx];
  assign empty = (rd_idx == wr_idx) && (rd_wrap == wr_wrap);
  assign full  = (rd_idx == wr_idx) && (rd_wrap != wr_wrap);

endmodule

// File: rtl/mem_response_router.sv
// Routes memory read responses back to requesters in issue order.
// Ports: issue_valid/issue_slave/issue_ready, masters[] in, slaves[] out.
// Optional slave output register: MEM_RESPONSE_ROUTER_OUTPUT_REG_EN.
module mem_response_router
  import mem_pkg::*;
#(
  parameter int SLAVE_PORTS     = 1,
  parameter int MASTER_PORTS    = 1,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SW = idx_w(SLAVE_PORTS),
  localparam int MW = idx_w(MASTER_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MASTER_PORTS-1:0]         issue_valid,
  input  logic [MASTER_PORTS-1:0][SW-1:0] issue_slave,
  output logic [MASTER_PORTS-1:0]         issue_ready,
  std_mem_intf.in                         masters [MASTER_PORTS],
  std_mem_intf.out                        slaves  [SLAVE_PORTS]
);

  logic [MASTER_PORTS-1:0] m_valid, m_ready;
  logic [MASTER_PORTS-1:0] mq_empty, mq_full, mq_pop;
  logic [DATA_WIDTH-1:0]   m_data  [MASTER_PORTS];
  logic [SW-1:0]           mq_head [MASTER_PORTS];

  logic [SLAVE_PORTS-1:0]  s_ready, s_valid, s_pvalid, sink_ok;
  logic [SLAVE_PORTS-1:0]  sq_empty, sq_full, sq_push, sq_pop;
  logic [MW-1:0]           sq_head [SLAVE_PORTS];
  logic [MW-1:0]           sq_din  [SLAVE_PORTS];
  logic [DATA_WIDTH-1:0]   s_data  [SLAVE_PORTS];
  logic [DATA_WIDTH-1:0]   s_pdata [SLAVE_PORTS];
  logic [MASTER_PORTS-1:0] pair    [SLAVE_PORTS];

  for (genvar g = 0; g < MASTER_PORTS; g++) begin : g_m
    assign m_valid[g]       = masters[g].valid;
    assign m_data[g]        = masters[g].data;
    assign masters[g].ready = m_ready[g];

    mem_index_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(SW)) u_mq (
      .clk   (clk),
      .rst   (rst),
      .push  (issue_valid[g]),
      .din   (issue_slave[g]),
      .pop   (mq_pop[g]),
      .head  (mq_head[g]),
      .empty (mq_empty[g]),
      .full  (mq_full[g])
    );
  end

  for (genvar g = 0; g < SLAVE_PORTS; g++) begin : g_s
    assign s_ready[g]      = slaves[g].ready;
    assign slaves[g].valid = s_valid[g];
    assign slaves[g].data  = s_data[g];

    mem_index_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(MW)) u_sq (
      .clk   (clk),
      .rst   (rst),
      .push  (sq_push[g]),
      .din   (sq_din[g]),
      .pop   (sq_pop[g]),
      .head  (sq_head[g]),
      .empty (sq_empty[g]),
      .full  (sq_full[g])
    );
  end

  // At most one master fires per slave per cycle, so a plain
  // priority scan is enough to pick the pushed master index.
  always_comb begin
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      sq_push[s] = 1'b0;
      sq_din[s]  = '0;
      for (int m = 0; m < MASTER_PORTS; m++) begin
        if (issue_valid[m] && issue_slave[m] == SW'(s)) begin
          sq_push[s] = 1'b1;
          sq_din[s]  = MW'(m);
        end
      end
    end
  end

  // Pairing needs both heads to point at each other; this is
  // unique per slave, so no arbitration.
  always_comb begin
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      s_pvalid[s] = 1'b0;
      s_pdata[s]  = '0;
      for (int m = 0; m < MASTER_PORTS; m++) begin
        pair[s][m] = !mq_empty[m] && mq_head[m] == SW'(s) &&
                     !sq_empty[s] && sq_head[s] == MW'(m);
        if (pair[s][m]) begin
          s_pvalid[s] = m_valid[m];
          s_pdata[s]  = m_data[m];
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < MASTER_PORTS; m++) begin
      m_ready[m] = 1'b0;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
        if (pair[s][m] && sink_ok[s]) m_ready[m] = 1'b1;
      end
    end
  end

  assign mq_pop = m_valid & m_ready;
  assign sq_pop = s_pvalid & sink_ok;

  // Occupancy only: a pop this cycle does not reopen a slot.
  always_comb begin
    for (int m = 0; m < MASTER_PORTS; m++) begin
      issue_ready[m] = !mq_full[m] && !(|sq_full);
    end
  end

`ifdef MEM_RESPONSE_ROUTER_OUTPUT_REG_EN
  logic [SLAVE_PORTS-1:0] reg_v;
  logic [DATA_WIDTH-1:0]  reg_d [SLAVE_PORTS];

  assign sink_ok = ~reg_v | s_ready;

  always_ff @(posedge clk) begin
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      if (rst) begin
        reg_v[s] <= 1'b0;
      end else if (sq_pop[s]) begin
        reg_v[s] <= 1'b1;
        reg_d[s] <= s_pdata[s];
      end else if (s_ready[s]) begin
        reg_v[s] <= 1'b0;
      end
    end
  end

  assign s_valid = reg_v;
  assign s_data  = reg_d;
`else
  assign sink_ok = s_ready;
  assign s_valid = s_pvalid;
  assign s_data  = s_pdata;
`endif

endmodule

// File: tb/tb_mem_response_router.sv
// Scoreboard bench for mem_response_router, 2 slaves x 2 masters.
// Expected data is queued per slave in issue order.
module tb_mem_response_router;

  localparam int SP = 2;
  localparam int MP = 2;
  localparam int DW = 32;
  localparam int MO = 2;

`ifdef MEM_RESPONSE_ROUTER_OUTPUT_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [MP-1:0]        iv  = '0;
  logic [MP-1:0][0:0]   isl = '0;
  logic [MP-1:0]        irdy;
  logic [MP-1:0]        mv  = '0;
  logic [MP-1:0]        mr;
  logic [DW-1:0]        md [MP];
  logic [SP-1:0]        sv;
  logic [SP-1:0]        sr  = '1;
  logic [DW-1:0]        sd [SP];

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] exp_q [SP][$];

  std_mem_intf #(.DATA_WIDTH(DW)) m_if [MP] ();
  std_mem_intf #(.DATA_WIDTH(DW)) s_if [SP] ();

  for (genvar g = 0; g < MP; g++) begin : g_m
    assign m_if[g].valid = mv[g];
    assign m_if[g].data  = md[g];
    assign mr[g]         = m_if[g].ready;
  end

  for (genvar g = 0; g < SP; g++) begin : g_s
    assign s_if[g].ready = sr[g];
    assign sv[g]         = s_if[g].valid;
    assign sd[g]         = s_if[g].data;
  end

  mem_response_router #(
    .SLAVE_PORTS     (SP),
    .MASTER_PORTS    (MP),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (iv),
    .issue_slave (isl),
    .issue_ready (irdy),
    .masters     (m_if),
    .slaves      (s_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Delivered responses are popped from the per-slave queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    for (int s = 0; s < SP; s++) begin
      if (!rst && sv[s] && sr[s]) begin
        checks++;
        if (exp_q[s].size() == 0) begin
          $display("FAIL sb_extra s%0d: got %h, required none", s, sd[s]);
        end else begin
          e = exp_q[s].pop_front();
          if (sd[s] !== e)
            $display("FAIL sb_data s%0d: got %h, required %h", s, sd[s], e);
          else
            passed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input int s);
    iv[m]  = 1'b1;
    isl[m] = 1'(s);
    step();
    iv[m]  = 1'b0;
  endtask

  task automatic respond(input int m, input logic [DW-1:0] d,
                         output bit ok);
    ok    = 1'b0;
    mv[m] = 1'b1;
    md[m] = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (mr[m]) ok = 1'b1;
      step();
    end
    mv[m] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (sv !== 2'b00) $display("FAIL rst_sv: got %b, required 00", sv);
    else passed++;
    checks++;
    if (mr !== 2'b00) $display("FAIL rst_mr: got %b, required 00", mr);
    else passed++;
    checks++;
    if (irdy !== 2'b11) $display("FAIL rst_irdy: got %b, required 11", irdy);
    else passed++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    exp_q[0].push_back(32'hDEADBEEF);
    iv[0]  = 1'b1;
    isl[0] = 1'b0;
    mv[0]  = 1'b1;
    md[0]  = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (mr[0] !== 1'b0) $display("FAIL single_same_cycle_mr: got %b, required 0", mr[0]);
    else passed++;
    step();
    iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mr[0] !== 1'b1) $display("FAIL single_mr: got %b, required 1", mr[0]);
    else passed++;
    checks++;
    if (sv[0] !== !REG_EN) $display("FAIL single_sv_t0: got %b, required %b", sv[0], !REG_EN);
    else passed++;
    step();
    mv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (sv[0] !== REG_EN) $display("FAIL single_sv_t1: got %b, required %b", sv[0], REG_EN);
    else passed++;
    step();
    checks++;
    if (exp_q[0].size() != 0) $display("FAIL single_drain: got %0d left, required 0", exp_q[0].size());
    else passed++;
    checks++;
    if (irdy !== 2'b11) $display("FAIL single_irdy: got %b, required 11", irdy);
    else passed++;
    mv[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (mr[0] !== 1'b0) $display("FAIL single_empty_mr: got %b, required 0", mr[0]);
    else passed++;
    step();
    mv[0] = 1'b0;
  endtask

  task automatic test_cross_order();
    bit ok0, ok1;
    issue(1, 0);
    exp_q[0].push_back(32'h1);
    issue(0, 0);
    exp_q[0].push_back(32'h0);
    fork
      respond(0, 32'h0, ok0);
      begin
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (mr[0] !== 1'b0) $display("FAIL cross_stall: got %b, required 0", mr[0]);
          else passed++;
        end
        step();
        respond(1, 32'h1, ok1);
      end
    join
    repeat (2) step();
    checks++;
    if (!(ok0 && ok1)) $display("FAIL cross_timeout: got %b%b, required 11", ok0, ok1);
    else passed++;
    checks++;
    if (exp_q[0].size() != 0) $display("FAIL cross_drain: got %0d left, required 0", exp_q[0].size());
    else passed++;
  endtask

  task automatic test_shared_mem();
    bit ok_a, ok_b, ok_c;
    issue(0, 1);
    exp_q[1].push_back(32'hA);
    issue(0, 0);
    exp_q[0].push_back(32'hB);
    respond(0, 32'hA, ok_a);
    issue(0, 1);
    exp_q[1].push_back(32'hC);
    respond(0, 32'hB, ok_b);
    respond(0, 32'hC, ok_c);
    repeat (2) step();
    checks++;
    if (!(ok_a && ok_b && ok_c))
      $display("FAIL shared_timeout: got %b%b%b, required 111", ok_a, ok_b, ok_c);
    else passed++;
    checks++;
    if (exp_q[0].size() != 0) $display("FAIL shared_drain_s0: got %0d left, required 0", exp_q[0].size());
    else passed++;
    checks++;
    if (exp_q[1].size() != 0) $display("FAIL shared_drain_s1: got %0d left, required 0", exp_q[1].size());
    else passed++;
  endtask

  task automatic test_full();
    bit ok;
    issue(0, 0);
    exp_q[0].push_back(32'h11);
    issue(0, 0);
    exp_q[0].push_back(32'h22);
    @(negedge clk);
    checks++;
    if (irdy !== 2'b00) $display("FAIL full_irdy: got %b, required 00", irdy);
    else passed++;
    step();
    mv[0] = 1'b1;
    md[0] = 32'h11;
    @(negedge clk);
    checks++;
    if (mr[0] !== 1'b1) $display("FAIL full_pop_mr: got %b, required 1", mr[0]);
    else passed++;
    checks++;
    if (irdy[0] !== 1'b0) $display("FAIL full_pop_irdy: got %b, required 0", irdy[0]);
    else passed++;
    step();
    mv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b1) $display("FAIL full_after_irdy: got %b, required 1", irdy[0]);
    else passed++;
    step();
    respond(0, 32'h22, ok);
    repeat (2) step();
    checks++;
    if (!ok) $display("FAIL full_timeout: got 0, required 1");
    else passed++;
    checks++;
    if (exp_q[0].size() != 0) $display("FAIL full_drain: got %0d left, required 0", exp_q[0].size());
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    sr[0] = 1'b0;
    issue(1, 0);
    exp_q[0].push_back(32'h55AA);
    fork
      respond(1, 32'h55AA, ok);
      begin
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (exp_q[0].size() != 1)
            $display("FAIL bp_hold: got %0d queued, required 1", exp_q[0].size());
          else passed++;
        end
        step();
        sr[0] = 1'b1;
      end
    join
    repeat (3) step();
    checks++;
    if (!ok) $display("FAIL bp_timeout: got 0, required 1");
    else passed++;
    checks++;
    if (exp_q[0].size() != 0) $display("FAIL bp_drain: got %0d left, required 0", exp_q[0].size());
    else passed++;
    checks++;
    if (sv[0] !== 1'b0) $display("FAIL bp_dup_sv: got %b, required 0", sv[0]);
    else passed++;
  endtask

  task automatic test_unexpected_reset();
    mv[0] = 1'b1;
    md[0] = 32'hBAD0BAD0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mr[0] !== 1'b0) $display("FAIL unexp_mr: got %b, required 0", mr[0]);
      else passed++;
    end
    step();
    mv[0] = 1'b0;
    iv     = 2'b11;
    isl[0] = 1'b0;
    isl[1] = 1'b1;
    step();
    iv = 2'b00;
    issue(0, 1);
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b0) $display("FAIL rst3_full: got %b, required 0", irdy[0]);
    else passed++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv  = 2'b11;
    @(negedge clk);
    checks++;
    if (sv !== 2'b00) $display("FAIL rst3_sv: got %b, required 00", sv);
    else passed++;
    checks++;
    if (irdy !== 2'b11) $display("FAIL rst3_irdy: got %b, required 11", irdy);
    else passed++;
    checks++;
    if (mr !== 2'b00) $display("FAIL rst3_mr: got %b, required 00", mr);
    else passed++;
    step();
    mv = 2'b00;
    step();
  endtask

  initial begin
    md[0] = '0;
    md[1] = '0;
    test_reset();
    test_single();
    test_cross_order();
    test_shared_mem();
    test_full();
    test_backpressure();
    test_unexpected_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
